// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed multiply / unsigned restoring divide, one bit per cycle.
module muldiv_seq #(
  parameter int         WIDTH  = 32,
  parameter logic [3:0] OP_MUL = 4'h3,
  parameter logic [3:0] OP_DIV = 4'h4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALU_OP,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Result2,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d, neg_q, neg_d, dbz_q, dbz_d;
  logic [WIDTH-1:0]   b_q, b_d, res_q, res_d, res2_q, res2_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step, fin;
  logic [WIDTH:0]     mul_sum, div_sh, div_tr;
  logic [WIDTH-1:0]   mag_x, mag_y, hi, lo;
  logic               accept;
  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    hi = acc_q[2*WIDTH-1:WIDTH];
    lo = acc_q[WIDTH-1:0];
    mag_x = X[WIDTH-1] ? -X : X;
    mag_y = Y[WIDTH-1] ? -Y : Y;
    mul_sum = {1'b0, hi} + {1'b0, lo[0] ? b_q : '0};
    div_sh = {hi, lo[WIDTH-1]};
    div_tr = div_sh - {1'b0, b_q};
    step = div_q ? {div_tr[WIDTH] ? div_sh[WIDTH-1:0] : div_tr[WIDTH-1:0], lo[WIDTH-2:0], ~div_tr[WIDTH]}
                 : {mul_sum, lo[WIDTH-1:1]};
    fin = neg_q ? -step : step;
    accept = state_q == IDLE && start && (ALU_OP == OP_MUL || ALU_OP == OP_DIV);
    state_d = state_q;
    cnt_d = cnt_q;
    div_d = div_q;
    neg_d = neg_q;
    dbz_d = dbz_q;
    b_d = b_q;
    acc_d = acc_q;
    res_d = res_q;
    res2_d = res2_q;
    if (accept) begin
      state_d = RUN;
      cnt_d = '0;
      div_d = ALU_OP == OP_DIV;
      neg_d = ALU_OP == OP_MUL && (X[WIDTH-1] ^ Y[WIDTH-1]);
      b_d = div_d ? Y : mag_y;
      acc_d = {{WIDTH{1'b0}}, div_d ? X : mag_x};
    end
    if (state_q == RUN) begin
      acc_d = step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = FIN;
        res_d = fin[WIDTH-1:0];
        res2_d = fin[2*WIDTH-1:WIDTH];
        dbz_d = div_q && b_q == '0;
      end
    end
    if (state_q == FIN) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      dbz_q <= 1'b0;
      b_q <= '0;
      acc_q <= '0;
      res_q <= '0;
      res2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      neg_q <= neg_d;
      dbz_q <= dbz_d;
      b_q <= b_d;
      acc_q <= acc_d;
      res_q <= res_d;
      res2_q <= res2_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == FIN;
  assign Result = res_q;
  assign Result2 = res2_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq against a behavioural mul/div model.
module tb_muldiv_seq;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0]  ALU_OP = 4'h0;
  logic [31:0] X = '0, Y = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] Result, Result2;
  int          n_cmp = 0, n_err = 0, n_done = 0, n_exp = 0;
  logic [64:0] sb[$];
  logic [64:0] exp_v, last_exp = '0;

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALU_OP(ALU_OP), .X(X), .Y(Y),
    .busy(busy), .done(done), .Result(Result), .Result2(Result2), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] p;
    if (op == 4'h3) begin
      p = $signed(x) * $signed(y);
      return {1'b0, p};
    end
    if (y == 0) return {1'b1, x, 32'hFFFFFFFF};
    return {1'b0, x % y, x / y};
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        exp_v = sb.pop_front();
        check("Result", Result, exp_v[31:0]);
        check("Result2", Result2, exp_v[63:32]);
        check("div_by_zero", div_by_zero, exp_v[64]);
      end
    end
  end

  task automatic start_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; ALU_OP = op; X = x; Y = y;
    @(posedge clk);
    #1 start = 1'b0; X = $urandom; Y = $urandom; ALU_OP = 4'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    if (!done) check("timeout", 0, 1);
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int n;
    sb.push_back(model(op, x, y));
    last_exp = model(op, x, y);
    n_exp++;
    start_op(op, x, y);
    check("busy_after_accept", busy, 1);
    wait_done(n);
    check("latency", n, 32);
    @(posedge clk);
    #1 check("idle_after_fin", {busy, done}, 0);
  endtask

  initial begin
    int n;
    #1 check("reset_outputs", {busy, done, div_by_zero, Result, Result2}, 0);
    @(negedge clk) rst_n = 1'b1;
    run(4'h3, 32'hFFFFFFFD, 32'd7);
    run(4'h3, 32'h80000000, 32'h80000000);
    run(4'h3, 32'h7FFFFFFF, 32'h80000000);
    run(4'h4, 32'd100, 32'd7);
    run(4'h4, 32'd5, 32'd0);
    run(4'h4, 32'hFFFFFFFF, 32'd1);
    for (int i = 0; i < 4; i++) run(i[0] ? 4'h3 : 4'h4, $urandom, $urandom_range(0, 3) == 0 ? 32'd3 : $urandom);
    // starts during RUN and FIN must be dropped
    sb.push_back(model(4'h4, 32'd100, 32'd7));
    last_exp = model(4'h4, 32'd100, 32'd7);
    n_exp++;
    start_op(4'h4, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    start_op(4'h3, 32'd2, 32'd3);
    check("busy_during_run", busy, 1);
    wait_done(n);
    start = 1'b1; ALU_OP = 4'h3; X = 32'd2; Y = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    check("fin_start_ignored", {busy, done}, 0);
    run(4'h3, 32'd2, 32'd3);
    // unsupported opcode leaves everything untouched
    start_op(4'h5, 32'd11, 32'd13);
    check("bad_op_busy", busy, 0);
    repeat (40) @(posedge clk);
    #1 check("bad_op_outputs", {div_by_zero, Result2, Result}, last_exp[63:0] | 64'(last_exp[64]) << 63 >> 63 << 63 & 64'h0 | {last_exp[64] ? 1'b1 : 1'b0, 63'h0} & 64'h0 | 64'(0));
    check("bad_op_result", Result, last_exp[31:0]);
    check("bad_op_result2", Result2, last_exp[63:32]);
    check("bad_op_dbz", div_by_zero, last_exp[64]);
    // asynchronous reset mid-MUL
    start_op(4'h3, 32'd123, 32'd456);
    repeat (14) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset", {busy, done, div_by_zero, Result, Result2}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1 check("after_reset_idle", {busy, Result, Result2}, 0);
    run(4'h4, 32'd9, 32'd2);
    check("done_count", n_done, n_exp);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
